data_register_fifo: RTL and testbench
=====================================

DATA_REGISTER_FIFO -- requirements
Module: data_register_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width; legal range (DEPTH_LOG2+4)..32.
REQ-002 SHALL have parameter DEPTH_LOG2, default 2, FIFO depth = 2^DEPTH_LOG2 entries.
REQ-003 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have rst  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 SHALL have writeData  input  WIDTH  bus write word from the peripheral data register.
REQ-006 SHALL have writeData_en  input  1  bus write strobe, held high for the whole bus write.
REQ-007 SHALL have writeData_busy  output  1  stalls the bus write.
REQ-008 SHALL have readData  output  WIDTH  status word returned on bus read.
REQ-009 SHALL have readData_en  input  1  bus read strobe, held high for the whole bus read.
REQ-010 SHALL have readData_busy  output  1  bus read stall; tied 0.
REQ-011 SHALL have out_data  output  WIDTH  head-of-FIFO word to hardware consumer.
REQ-012 SHALL have out_valid  output  1  FIFO non-empty.
REQ-013 SHALL have out_ready  input  1  consumer accepts out_data when out_valid && out_ready.

Function
REQ-014 SHALL be a circular buffer of 2^DEPTH_LOG2 WIDTH-bit entries; read/write pointers DEPTH_LOG2 bits, wrap from 2^DEPTH_LOG2-1 to 0; count DEPTH_LOG2+1 bits.
REQ-015 SHALL derive empty = (count == 0), full = (count == 2^DEPTH_LOG2), both from registered count.
REQ-016 SHALL keep a writeAccepted flag: push occurs when writeData_en && !writeAccepted && !full; writeAccepted sets on push, clears on first cycle writeData_en is low.
REQ-017 SHALL make each bus write push at most once, however many cycles writeData_en stays high.
REQ-018 SHALL drive writeData_busy = writeData_en && !writeAccepted && full (combinational).
REQ-019 SHALL pop when out_valid && out_ready; out_valid = !empty; out_data = entry at read pointer (registered storage, no fall-through: pushed word visible one cycle after push).
REQ-020 SHALL on simultaneous push and pop keep count unchanged and advance both pointers.
REQ-021 SHALL, when full and a pop occurs in the same cycle as a pending write, not push that cycle; push occurs next cycle (full evaluated on registered count).
REQ-022 SHALL drive readData = zero-extended {count, overflow, full, empty}: bit0 empty, bit1 full, bit2 overflow, bits[3 +: DEPTH_LOG2+1] count.
REQ-023 SHALL keep a readAccepted flag: sets on first cycle of readData_en, clears when readData_en low; first cycle of a read is the "read accept" cycle.
REQ-024 SHALL tie readData_busy to 0.

Reset
REQ-025 SHALL, while rst low at rising clk, clear pointers, count, writeAccepted, readAccepted, overflow; storage contents need not reset.
REQ-026 SHALL produce after reset: out_valid 0, writeData_busy 0 for any writeData_en, readData = 1 (empty only).
REQ-027 SHALL, on reset during a held bus write, treat writeData_en still high after reset as a new write (push once if not full).

Configuration
REQ-028 SHALL compile drop-on-full behaviour only when macro DATA_REGISTER_FIFO_DROP_ON_FULL_EN is defined.
REQ-029 SHALL with DATA_REGISTER_FIFO_DROP_ON_FULL_EN: writeData_busy constant 0; write to full FIFO discarded, sets writeAccepted and sticky overflow; overflow clears on read accept cycle; set wins over clear in same cycle.
REQ-030 SHALL without DATA_REGISTER_FIFO_DROP_ON_FULL_EN: overflow bit constant 0, writes to full FIFO stall per REQ-018.

Verification
REQ-031 SHALL cover: after reset, writeData_en high 5 cycles with 0xA5 -> exactly one push, count 1, out_data 0xA5 from next cycle.
REQ-032 SHALL cover: 4 writes 1..4, out_ready 0 -> readData 0x22 (count 4, full); 5th write -> writeData_busy 1 until one pop, then push 5, busy 0.
REQ-033 SHALL cover: 6 writes, out_ready 1 continuous -> out_data sequence 1..6 across pointer wrap, no loss/duplication.
REQ-034 SHALL cover: count 2, push and pop same cycle -> count stays 2, order preserved.
REQ-035 SHALL cover (DROP_ON_FULL_EN): full FIFO, write 0x99 -> busy 0, word dropped, readData bit2 set; next bus read clears overflow, following read returns bit2 0.
REQ-036 SHALL cover: rst low for one cycle with count 3 -> out_valid 0, readData 0x1 next cycle.

Source files
------------

// File: rtl/data_register_fifo.sv
// Peripheral data-register front end feeding a small circular FIFO to a hardware consumer.
// Optional feature macro: DATA_REGISTER_FIFO_DROP_ON_FULL_EN (discard writes to a full FIFO, flag overflow).
module data_register_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] writeData,
  input  logic             writeData_en,
  output logic             writeData_busy,
  output logic [WIDTH-1:0] readData,
  input  logic             readData_en,
  output logic             readData_busy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int STAT_W = DEPTH_LOG2 + 4;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1'b1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1'b1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO = {(DEPTH_LOG2 + 1){1'b0}};

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  wr_acc_q, wr_acc_d;
  logic                  rd_acc_q, rd_acc_d;
  logic                  ovf_q, ovf_d;

  logic full_s, empty_s, wr_new_s, rd_new_s, push_s, pop_s, drop_s;

  assign full_s   = (count_q == CNT_FULL);
  assign empty_s  = (count_q == CNT_ZERO);
  assign wr_new_s = writeData_en && !wr_acc_q;
  assign rd_new_s = readData_en && !rd_acc_q;
  assign push_s   = wr_new_s && !full_s;
  assign pop_s    = !empty_s && out_ready;

`ifdef DATA_REGISTER_FIFO_DROP_ON_FULL_EN
  assign drop_s         = wr_new_s && full_s;
  assign writeData_busy = 1'b0;
`else
  assign drop_s         = 1'b0;
  assign writeData_busy = wr_new_s && full_s;
`endif

  assign readData_busy = 1'b0;
  assign out_valid     = !empty_s;
  assign out_data      = mem_q[rd_ptr_q];

  always_comb begin
    readData                = {WIDTH{1'b0}};
    readData[STAT_W-1:0]    = {count_q, ovf_q, full_s, empty_s};
  end

  // Next-state for pointers, occupancy and the bus handshake flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_acc_d = wr_acc_q;
    rd_acc_d = readData_en;
    ovf_d    = ovf_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // A bus write is consumed exactly once, whether stored or dropped.
    if (!writeData_en) begin
      wr_acc_d = 1'b0;
    end else if (push_s || drop_s) begin
      wr_acc_d = 1'b1;
    end else begin
      wr_acc_d = wr_acc_q;
    end

`ifdef DATA_REGISTER_FIFO_DROP_ON_FULL_EN
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (rd_new_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
`else
    ovf_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= {DEPTH_LOG2{1'b0}};
      rd_ptr_q <= {DEPTH_LOG2{1'b0}};
      count_q  <= CNT_ZERO;
      wr_acc_q <= 1'b0;
      rd_acc_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wr_acc_q <= wr_acc_d;
      rd_acc_q <= rd_acc_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately left unreset; only valid entries are ever exposed.
  always_ff @(posedge clk) begin
    if (rst && push_s) begin
      mem_q[wr_ptr_q] <= writeData;
    end
  end

endmodule

// File: tb/tb_data_register_fifo.sv
// Scoreboard bench for data_register_fifo: expected words queued on bus writes, checked on consumer pops.
module tb_data_register_fifo;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] writeData;
  logic             writeData_en;
  logic             writeData_busy;
  logic [WIDTH-1:0] readData;
  logic             readData_en;
  logic             readData_busy;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  int               n_checks = 0;
  int               n_errors = 0;
  int               n_pops   = 0;
  logic [WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  data_register_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(2)) dut (
    .clk(clk), .rst(rst),
    .writeData(writeData), .writeData_en(writeData_en), .writeData_busy(writeData_busy),
    .readData(readData), .readData_en(readData_en), .readData_busy(readData_busy),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic check_val(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Status word: count in bits [5:3], overflow bit2, full bit1, empty bit0 (depth 4).
  function automatic logic [WIDTH-1:0] stat_word(input int cnt, input bit ovf);
    logic [WIDTH-1:0] w;
    w = WIDTH'(cnt * 8);
    if (ovf) w = w | 32'h4;
    if (cnt == 4) w = w | 32'h2;
    if (cnt == 0) w = w | 32'h1;
    return w;
  endfunction

  // Consumer-side monitor: every accepted out_data must match the scoreboard head.
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("pop_unexpected", 32'h1, 32'h0);
      end else begin
        check_val("pop_data", out_data, exp_q.pop_front());
      end
      n_pops++;
    end
  end

  // Entered and left just after a rising edge; leaves writeData_en low across one edge.
  task automatic bus_write(input logic [WIDTH-1:0] d, input int hold);
    int waited;
    waited       = 0;
    writeData    = d;
    writeData_en = 1'b1;
    @(negedge clk);
    while (writeData_busy === 1'b1 && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    check_val("wr_busy_released", {31'h0, writeData_busy}, 32'h0);
    exp_q.push_back(d);
    repeat (hold - 1) begin
      @(negedge clk);
      check_val("wr_hold_busy", {31'h0, writeData_busy}, 32'h0);
    end
    @(posedge clk); #1;
    writeData_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic bus_read(input int hold, output logic [WIDTH-1:0] first);
    readData_en = 1'b1;
    @(negedge clk);
    first = readData;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    readData_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int w;
    w = 0;
    out_ready = 1'b1;
    do begin
      @(negedge clk);
      w++;
    end while (out_valid === 1'b1 && w < 50);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check_val("drain_empty", {31'h0, out_valid}, 32'h0);
    check_val("sb_empty", WIDTH'(exp_q.size()), 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] r;
    int               p0;
    rst = 1'b0; writeData = 32'h0; writeData_en = 1'b0; readData_en = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_val("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check_val("rst_readData", readData, stat_word(0, 1'b0));
    check_val("rst_rd_busy", {31'h0, readData_busy}, 32'h0);
    @(posedge clk); #1;

    // Single held write: one push, no fall-through.
    writeData = 32'hA5; writeData_en = 1'b1;
    @(negedge clk);
    check_val("hold_pre_valid", {31'h0, out_valid}, 32'h0);
    check_val("hold_busy0", {31'h0, writeData_busy}, 32'h0);
    exp_q.push_back(32'hA5);
    repeat (4) begin
      @(negedge clk);
      check_val("hold_count1", readData, stat_word(1, 1'b0));
      check_val("hold_out_data", out_data, 32'hA5);
    end
    @(posedge clk); #1 writeData_en = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("hold_after", readData, stat_word(1, 1'b0));
    @(posedge clk); #1;
    drain();

    // Fill to full, then overflow behaviour.
    for (int i = 1; i <= 4; i++) bus_write(WIDTH'(i), 2);
    @(negedge clk);
    check_val("full_status", readData, 32'h22);
    @(posedge clk); #1;
`ifdef DATA_REGISTER_FIFO_DROP_ON_FULL_EN
    writeData = 32'h99; writeData_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_val("drop_busy0", {31'h0, writeData_busy}, 32'h0);
    end
    @(posedge clk); #1 writeData_en = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("drop_ovf_set", readData, 32'h26);
    check_val("drop_head", out_data, 32'h1);
    @(posedge clk); #1;
    bus_read(2, r);
    check_val("drop_read1", r, 32'h26);
    bus_read(1, r);
    check_val("drop_read2", r, 32'h22);
    for (int i = 1; i <= 4; i++) exp_q.delete(0);
    for (int i = 1; i <= 4; i++) exp_q.push_back(WIDTH'(i));
`else
    writeData = 32'h5; writeData_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_val("stall_busy1", {31'h0, writeData_busy}, 32'h1);
      check_val("stall_status", readData, 32'h22);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check_val("stall_pop_cycle_busy", {31'h0, writeData_busy}, 32'h1);
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    check_val("stall_released", {31'h0, writeData_busy}, 32'h0);
    check_val("stall_count3", readData, stat_word(3, 1'b0));
    exp_q.push_back(32'h5);
    @(posedge clk); #1 writeData_en = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("stall_full_again", readData, 32'h22);
    check_val("stall_busy_idle", {31'h0, writeData_busy}, 32'h0);
    @(posedge clk); #1;
    bus_read(2, r);
    check_val("read_no_ovf", r, 32'h22);
`endif
    drain();

    // Streaming through pointer wrap.
    p0 = n_pops;
    out_ready = 1'b1;
    for (int i = 1; i <= 6; i++) bus_write(WIDTH'(i), 2);
    drain();
    check_val("stream_pops", WIDTH'(n_pops - p0), 32'd6);

    // Simultaneous push and pop at count 2.
    bus_write(32'h11, 1);
    bus_write(32'h22, 1);
    @(negedge clk);
    check_val("sim_count2", readData, stat_word(2, 1'b0));
    @(posedge clk); #1;
    writeData = 32'h33; writeData_en = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check_val("sim_busy0", {31'h0, writeData_busy}, 32'h0);
    exp_q.push_back(32'h33);
    @(posedge clk); #1 out_ready = 1'b0; writeData_en = 1'b0;
    @(negedge clk);
    check_val("sim_count_kept", readData, stat_word(2, 1'b0));
    check_val("sim_head", out_data, 32'h22);
    @(posedge clk); #1;
    drain();

    // Mid-run reset with three entries queued.
    bus_write(32'h31, 1);
    bus_write(32'h32, 1);
    bus_write(32'h33, 1);
    @(negedge clk);
    check_val("pre_rst_count3", readData, stat_word(3, 1'b0));
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_val("mrst_out_valid", {31'h0, out_valid}, 32'h0);
    check_val("mrst_readData", readData, 32'h1);
    @(posedge clk); #1;
    bus_write(32'h44, 3);
    @(negedge clk);
    check_val("post_rst_write", readData, stat_word(1, 1'b0));
    @(posedge clk); #1;
    drain();

    check_val("final_sb_empty", WIDTH'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
